approx_mult_err_monitor: RTL and testbench

- Downstream evaluation stage for the 8x8 approximate multipliers in the library.
- Consumes operand pairs with the approximate product each multiplier produced, and computes the exact product internally.
- Over a run of N_SAMPLES valid samples, accumulates error statistics: sum of absolute error, signed error sum (bias), max absolute error, error count.
- Statistics are read by the characterisation bench or a host after done.

---
 rtl/err_mon_pkg.sv | 46 ++++
 rtl/err_calc_stage.sv | 81 ++++++++
 rtl/approx_mult_err_monitor.sv | 135 +++++++++++++
 tb/tb_approx_mult_err_monitor.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/err_mon_pkg.sv
// rtl/err_mon_pkg.sv - shared types, constants and saturating adders for the error monitor
package err_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Transfer cycle plus two registered stages ahead of the accumulators
  localparam int PIPE_DEPTH = 3;

  // Widest accumulator supported; helpers work at this width and clamp to w bits
  localparam int SAT_W = 48;

  // Unsigned add of a 16-bit magnitude into a w-bit accumulator, clamped at 2^w-1
  function automatic logic [SAT_W-1:0] sat_add_u(input logic [SAT_W-1:0] acc,
                                                 input logic [15:0]      inc,
                                                 input int unsigned      w);
    logic [SAT_W:0] sum;
    logic [SAT_W:0] lim;
    sum = {1'b0, acc} + {{(SAT_W-15){1'b0}}, inc};
    lim = ({{SAT_W{1'b0}}, 1'b1} << w) - {{SAT_W{1'b0}}, 1'b1};
    if (sum > lim) return lim[SAT_W-1:0];
    return sum[SAT_W-1:0];
  endfunction

  // Signed add of a 17-bit error into a w-bit two's-complement accumulator, clamped both ways
  function automatic logic [SAT_W-1:0] sat_add_s(input logic signed [SAT_W-1:0] acc,
                                                 input logic signed [16:0]      inc,
                                                 input int unsigned             w);
    logic signed [SAT_W:0] sum;
    logic signed [SAT_W:0] hi;
    logic signed [SAT_W:0] lo;
    logic signed [SAT_W:0] one;
    one = {{SAT_W{1'b0}}, 1'b1};
    sum = $signed({acc[SAT_W-1], acc}) + $signed({{(SAT_W-16){inc[16]}}, inc});
    hi  = (one <<< (w - 1)) - one;
    lo  = -(one <<< (w - 1));
    if (sum > hi) return hi[SAT_W-1:0];
    if (sum < lo) return lo[SAT_W-1:0];
    return sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/err_calc_stage.sv
// rtl/err_calc_stage.sv - S1/S2 datapath: exact product, signed error, magnitude, nonzero flag
module err_calc_stage
  import err_mon_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clr,
  input  logic               i_valid,
  input  logic [7:0]         i_a,
  input  logic [7:0]         i_b,
  input  logic [15:0]        i_r_approx,
  output logic               o_s1_valid,
  output logic               o_valid,
  output logic signed [16:0] o_e,
  output logic [15:0]        o_abs_e,
  output logic               o_nz
);

  logic              r_s1_valid;
  logic [7:0]        r_s1_a;
  logic [7:0]        r_s1_b;
  logic [15:0]       r_s1_r;
  logic              r_s2_valid;
  logic signed [16:0] r_s2_e;
  logic [15:0]       r_s2_abs;
  logic              r_s2_nz;

  logic [15:0]        w_exact;
  logic signed [16:0] w_e;
  logic signed [16:0] w_neg_e;
  logic [15:0]        w_abs;

  // Error arithmetic on the S1 registers; |e| never exceeds 65535 so 16 bits suffice
  always_comb begin
    w_exact = r_s1_a * r_s1_b;
    w_e     = $signed({1'b0, r_s1_r}) - $signed({1'b0, w_exact});
    w_neg_e = -w_e;
    w_abs   = w_e[16] ? w_neg_e[15:0] : w_e[15:0];
  end

  // S1 capture of the accepted operands
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_r     <= '0;
    end else begin
      r_s1_valid <= i_valid;
      if (i_valid) begin
        r_s1_a <= i_a;
        r_s1_b <= i_b;
        r_s1_r <= i_r_approx;
      end
    end
  end

  // S2 capture of the error terms handed to the accumulators
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_s2_valid <= 1'b0;
      r_s2_e     <= '0;
      r_s2_abs   <= '0;
      r_s2_nz    <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_e   <= w_e;
        r_s2_abs <= w_abs;
        r_s2_nz  <= (w_e != 17'sd0);
      end
    end
  end

  assign o_s1_valid = r_s1_valid;
  assign o_valid    = r_s2_valid;
  assign o_e        = r_s2_e;
  assign o_abs_e    = r_s2_abs;
  assign o_nz       = r_s2_nz;

endmodule

// File: rtl/approx_mult_err_monitor.sv
// rtl/approx_mult_err_monitor.sv - run control, sample counting and error statistic accumulation
module approx_mult_err_monitor
  import err_mon_pkg::*;
#(
  parameter int N_SAMPLES = 256,
  parameter int ACC_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic [15:0]      r_approx,
  output logic             busy,
  output logic             done,
  output logic [15:0]      sample_cnt,
  output logic [15:0]      err_cnt,
  output logic [15:0]      max_abs_err,
  output logic [ACC_W-1:0] sum_abs_err,
  output logic [ACC_W-1:0] sum_err
);

  state_t r_state;
  state_t w_state_nxt;
  logic   w_clr;
  logic   w_ready;
  logic   w_xfer;
  logic   w_last_xfer;

  logic [15:0]      r_sample_cnt;
  logic [15:0]      r_err_cnt;
  logic [15:0]      r_max_abs;
  logic [ACC_W-1:0] r_sum_abs;
  logic [ACC_W-1:0] r_sum_err;

  logic               w_s1_valid;
  logic               w_s2_valid;
  logic signed [16:0] w_e;
  logic [15:0]        w_abs_e;
  logic               w_nz;
  logic [SAT_W-1:0]   w_sum_abs_wide;
  logic [SAT_W-1:0]   w_sum_err_wide;

  assign w_ready     = (r_state == RUN) && (r_sample_cnt < 16'(N_SAMPLES));
  assign w_xfer      = in_valid && w_ready;
  assign w_last_xfer = w_xfer && (r_sample_cnt == 16'(N_SAMPLES - 1));

  err_calc_stage u_calc (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_clr      (w_clr),
    .i_valid    (w_xfer),
    .i_a        (a),
    .i_b        (b),
    .i_r_approx (r_approx),
    .o_s1_valid (w_s1_valid),
    .o_valid    (w_s2_valid),
    .o_e        (w_e),
    .o_abs_e    (w_abs_e),
    .o_nz       (w_nz)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state, statistics clear and status decode; start only matters in IDLE and DONE
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RUN;
          w_clr       = 1'b1;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_last_xfer) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (!w_s1_valid && !w_s2_valid) w_state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          w_state_nxt = RUN;
          w_clr       = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Saturating accumulator updates computed at the helper width, then narrowed
  always_comb begin
    w_sum_abs_wide = sat_add_u(SAT_W'(r_sum_abs), w_abs_e, ACC_W);
    w_sum_err_wide = sat_add_s(SAT_W'($signed(r_sum_err)), w_e, ACC_W);
  end

  // Sample counting at transfer and S3 statistic accumulation
  always_ff @(posedge clk) begin
    if (rst || w_clr) begin
      r_sample_cnt <= '0;
      r_err_cnt    <= '0;
      r_max_abs    <= '0;
      r_sum_abs    <= '0;
      r_sum_err    <= '0;
    end else begin
      if (w_xfer) r_sample_cnt <= r_sample_cnt + 16'd1;
      if (w_s2_valid) begin
        if (w_nz) r_err_cnt <= r_err_cnt + 16'd1;
        if (w_abs_e > r_max_abs) r_max_abs <= w_abs_e;
        r_sum_abs <= w_sum_abs_wide[ACC_W-1:0];
        r_sum_err <= w_sum_err_wide[ACC_W-1:0];
      end
    end
  end

  assign in_ready    = w_ready;
  assign sample_cnt  = r_sample_cnt;
  assign err_cnt     = r_err_cnt;
  assign max_abs_err = r_max_abs;
  assign sum_abs_err = r_sum_abs;
  assign sum_err     = r_sum_err;

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// tb/tb_approx_mult_err_monitor.sv - directed table-driven bench for the approximate multiplier error monitor
module tb_approx_mult_err_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] r_approx;
  logic [3:0]  start;
  logic [3:0]  rdy;
  logic [3:0]  bsy;
  logic [3:0]  dn;
  logic [15:0] sc [4];
  logic [15:0] ec [4];
  logic [15:0] mx [4];
  logic [31:0] sa [3];
  logic [31:0] se [3];
  logic [23:0] sat_sa;
  logic [23:0] sat_se;

  int cmp_n  = 0;
  int fail_n = 0;

  always #5 clk = ~clk;

  approx_mult_err_monitor #(.N_SAMPLES(4), .ACC_W(32)) u_n4 (
    .clk(clk), .rst(rst), .start(start[0]), .in_valid(in_valid), .in_ready(rdy[0]),
    .a(a), .b(b), .r_approx(r_approx), .busy(bsy[0]), .done(dn[0]),
    .sample_cnt(sc[0]), .err_cnt(ec[0]), .max_abs_err(mx[0]),
    .sum_abs_err(sa[0]), .sum_err(se[0]));

  approx_mult_err_monitor #(.N_SAMPLES(3), .ACC_W(32)) u_n3 (
    .clk(clk), .rst(rst), .start(start[1]), .in_valid(in_valid), .in_ready(rdy[1]),
    .a(a), .b(b), .r_approx(r_approx), .busy(bsy[1]), .done(dn[1]),
    .sample_cnt(sc[1]), .err_cnt(ec[1]), .max_abs_err(mx[1]),
    .sum_abs_err(sa[1]), .sum_err(se[1]));

  approx_mult_err_monitor #(.N_SAMPLES(1), .ACC_W(32)) u_n1 (
    .clk(clk), .rst(rst), .start(start[2]), .in_valid(in_valid), .in_ready(rdy[2]),
    .a(a), .b(b), .r_approx(r_approx), .busy(bsy[2]), .done(dn[2]),
    .sample_cnt(sc[2]), .err_cnt(ec[2]), .max_abs_err(mx[2]),
    .sum_abs_err(sa[2]), .sum_err(se[2]));

  approx_mult_err_monitor #(.N_SAMPLES(300), .ACC_W(24)) u_sat (
    .clk(clk), .rst(rst), .start(start[3]), .in_valid(in_valid), .in_ready(rdy[3]),
    .a(a), .b(b), .r_approx(r_approx), .busy(bsy[3]), .done(dn[3]),
    .sample_cnt(sc[3]), .err_cnt(ec[3]), .max_abs_err(mx[3]),
    .sum_abs_err(sat_sa), .sum_err(sat_se));

  typedef struct {
    int          inst;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] r;
    bit          last;
    int          exp_sc;
    int          exp_ec;
    int          exp_mx;
    logic [31:0] exp_sa;
    logic [31:0] exp_se;
  } vec_t;

  vec_t tbl [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_n++;
    if (act !== exp) begin
      fail_n++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic get_stats(input int k, output logic [31:0] o_sa, output logic [31:0] o_se);
    if (k == 3) begin
      o_sa = {8'd0, sat_sa};
      o_se = {8'd0, sat_se};
    end else begin
      o_sa = sa[k];
      o_se = se[k];
    end
  endtask

  task automatic pulse_start(input int k);
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
  endtask

  // Present one sample, wait (bounded) for in_ready, let it transfer on the next edge
  task automatic send(input int k, input logic [7:0] va, input logic [7:0] vb, input logic [15:0] vr);
    int n;
    a = va; b = vb; r_approx = vr; in_valid = 1'b1;
    n = 0;
    while (!rdy[k] && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) chk($sformatf("ready_timeout_inst%0d", k), 64'(n), 64'd0);
    tick();
    in_valid = 1'b0;
  endtask

  // Count cycles from the last transfer until done, bounded
  task automatic wait_done(input int k, output int lat);
    lat = 0;
    while (!dn[k] && lat < 40) begin
      tick();
      lat++;
    end
    if (!dn[k]) chk($sformatf("done_timeout_inst%0d", k), 64'(dn[k]), 64'd1);
  endtask

  task automatic chk_zero(input int k, input string tag);
    logic [31:0] vsa, vse;
    get_stats(k, vsa, vse);
    chk({tag, "_sample_cnt"}, 64'(sc[k]), 64'd0);
    chk({tag, "_err_cnt"},    64'(ec[k]), 64'd0);
    chk({tag, "_max_abs"},    64'(mx[k]), 64'd0);
    chk({tag, "_sum_abs"},    64'(vsa),   64'd0);
    chk({tag, "_sum_err"},    64'(vse),   64'd0);
    chk({tag, "_busy"},       64'(bsy[k]), 64'd0);
    chk({tag, "_done"},       64'(dn[k]),  64'd0);
    chk({tag, "_in_ready"},   64'(rdy[k]), 64'd0);
  endtask

  task automatic chk_stats(input int k, input string tag, input int esc, input int eec,
                           input int emx, input logic [31:0] esa, input logic [31:0] ese);
    logic [31:0] vsa, vse;
    get_stats(k, vsa, vse);
    chk({tag, "_sample_cnt"}, 64'(sc[k]), 64'(esc));
    chk({tag, "_err_cnt"},    64'(ec[k]), 64'(eec));
    chk({tag, "_max_abs"},    64'(mx[k]), 64'(emx));
    chk({tag, "_sum_abs"},    64'(vsa),   64'(esa));
    chk({tag, "_sum_err"},    64'(vse),   64'(ese));
  endtask

  initial begin
    int lat;

    // inst, a, b, r_approx, last, expected sample/err/max/sum_abs/sum_err at done
    tbl.push_back('{0,   3,   5,    15, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 255, 255, 65025, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0,   0, 200,     0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0,  16,  16,   256, 1, 4, 0, 0, 0, 0});
    tbl.push_back('{1,  15,  15,   255, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1,  12,  10,   112, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1,   7,   9,    63, 1, 3, 2, 30, 32'd38, 32'd22});
    tbl.push_back('{2,   0,   0, 16'hFFFF, 1, 1, 1, 65535, 32'd65535, 32'd65535});

    rst = 1'b1; in_valid = 1'b0; start = '0; a = '0; b = '0; r_approx = '0;
    tick();
    tick();
    rst = 1'b0;
    chk_zero(0, "reset_n4");
    chk_zero(3, "reset_sat");

    // Table-driven runs
    for (int i = 0; i < tbl.size(); i++) begin
      if (i == 0 || tbl[i-1].last) pulse_start(tbl[i].inst);
      send(tbl[i].inst, tbl[i].a, tbl[i].b, tbl[i].r);
      if (tbl[i].last) begin
        chk($sformatf("drain_ready_v%0d", i), 64'(rdy[tbl[i].inst]), 64'd0);
        chk($sformatf("drain_busy_v%0d", i),  64'(bsy[tbl[i].inst]), 64'd1);
        wait_done(tbl[i].inst, lat);
        chk($sformatf("latency_v%0d", i), 64'(lat), 64'd3);
        chk_stats(tbl[i].inst, $sformatf("run_v%0d", i), tbl[i].exp_sc, tbl[i].exp_ec,
                  tbl[i].exp_mx, tbl[i].exp_sa, tbl[i].exp_se);
      end
    end

    // Saturation: 300 samples of +65535 into 24-bit accumulators
    pulse_start(3);
    for (int i = 0; i < 300; i++) send(3, 8'd0, 8'd0, 16'hFFFF);
    wait_done(3, lat);
    chk_stats(3, "sat", 300, 300, 65535, 32'd16777215, 32'd8388607);

    // Handshake: gaps, start mid-run, valid while not ready
    pulse_start(0);
    a = 8'd2; b = 8'd3; r_approx = 16'd7; in_valid = 1'b1;
    tick();
    chk("hs_cnt_after_first", 64'(sc[0]), 64'd1);
    in_valid = 1'b0;
    tick();
    chk("hs_cnt_after_gap", 64'(sc[0]), 64'd1);
    a = 8'd4; b = 8'd4; r_approx = 16'd10; in_valid = 1'b1; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    chk("hs_cnt_after_start", 64'(sc[0]), 64'd2);
    chk("hs_busy_after_start", 64'(bsy[0]), 64'd1);
    chk("hs_ready_after_start", 64'(rdy[0]), 64'd1);
    a = 8'd1; b = 8'd1; r_approx = 16'd1;
    tick();
    a = 8'd0; b = 8'd0; r_approx = 16'd0;
    tick();
    chk("hs_cnt_full", 64'(sc[0]), 64'd4);
    chk("hs_ready_drain", 64'(rdy[0]), 64'd0);
    tick();
    chk("hs_cnt_valid_in_drain", 64'(sc[0]), 64'd4);
    in_valid = 1'b0;
    wait_done(0, lat);
    in_valid = 1'b1;
    tick();
    tick();
    chk("hs_ready_done", 64'(rdy[0]), 64'd0);
    chk("hs_done_held", 64'(dn[0]), 64'd1);
    in_valid = 1'b0;
    chk_stats(0, "hs", 4, 2, 6, 32'd7, 32'hFFFF_FFFB);

    // Reset mid-run after 2 of 4 samples, then a clean run
    pulse_start(0);
    send(0, 8'd5, 8'd5, 16'd20);
    send(0, 8'd1, 8'd2, 16'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero(0, "midrst");
    tick();
    tick();
    chk_zero(0, "midrst_flush");
    pulse_start(0);
    send(0, 8'd3,  8'd5,  16'd15);
    send(0, 8'd2,  8'd2,  16'd5);
    send(0, 8'd10, 8'd10, 16'd90);
    send(0, 8'd0,  8'd0,  16'd0);
    wait_done(0, lat);
    chk("postrst_latency", 64'(lat), 64'd3);
    chk_stats(0, "postrst", 4, 2, 10, 32'd11, 32'hFFFF_FFF7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

endmodule
